gray_decade_encoder: RTL

- Sequential source for the team's segment-decoder display path.
- Holds one decimal digit, counts up or down, and parallel-loads.
- Encodes the digit into the 4-bit cyclic Gray decade code the display decoder consumes.
- Generates the decoder's active-low lamp-test (n_T) and blank (n_M) controls. The carry output allows multi-digit cascading.

---
 rtl/gray_decade_encoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gray_decade_encoder.sv
// ---------------------------------------------------------------------------
// gray_decade_encoder
//
// Purpose:
//   Single decimal digit counter (up/down, parallel load) for the segment
//   decoder display path. The digit is encoded into the cyclic Gray decade
//   code consumed by the decoder. The block also produces the decoder's
//   active-low lamp-test (n_T) and blank (n_M) controls. A one-cycle carry
//   pulse on every wrap allows multi-digit cascading.
//
// Optional feature (compile-time macro LAMP_TEST_TIMER_EN):
//   Defined   : a rising edge of lamp_test_req stretches n_T low for exactly
//               LT_CYCLES clocks, starting the cycle after the edge; a new
//               rising edge retriggers the timer.
//   Undefined : n_T is the registered inverse of lamp_test_req. No timer
//               hardware is built.
//
// Parameters:
//   MAX_DIGIT  highest count value (1..9); the counter wraps MAX_DIGIT<->0
//   LT_CYCLES  lamp-test stretch length in clocks (1..255), timer build only
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active-high
//   en             in   count enable, one step per cycle
//   up             in   1 = increment, 0 = decrement
//   load           in   parallel load strobe (has priority over en)
//   load_digit[4]  in   binary digit to load
//   lamp_test_req  in   active-high lamp-test request
//   blank_req      in   active-high blank request
//   X[4]           out  Gray decade code of the current digit
//   n_T            out  active-low lamp test
//   n_M            out  active-low blank
//   digit[4]       out  current digit, binary
//   carry          out  one-cycle wrap pulse (carry up / borrow down)
//   err            out  one-cycle pulse on an out-of-range load
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module gray_decade_encoder #(
   parameter int unsigned MAX_DIGIT = 9,
   parameter int unsigned LT_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       lamp_test_req,
   input  logic       blank_req,
   output logic [3:0] X,
   output logic       n_T,
   output logic       n_M,
   output logic [3:0] digit,
   output logic       carry,
   output logic       err
);

   localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

   logic [3:0] digit_q, digit_d;
   logic [3:0] x_q, x_d;
   logic       carry_q, carry_d;
   logic       err_q, err_d;
   logic       n_t_q, n_t_d;
   logic       n_m_q;

   // Cyclic Gray decade code: neighbours differ in one bit, including 9->0.
   function automatic logic [3:0] gray_enc(input logic [3:0] d);
      logic [3:0] g;
      case (d)
         4'd0:    g = 4'b0000;
         4'd1:    g = 4'b0001;
         4'd2:    g = 4'b0011;
         4'd3:    g = 4'b0010;
         4'd4:    g = 4'b0110;
         4'd5:    g = 4'b0111;
         4'd6:    g = 4'b0101;
         4'd7:    g = 4'b0100;
         4'd8:    g = 4'b1100;
         4'd9:    g = 4'b1000;
         default: g = 4'b0000;
      endcase
      return g;
   endfunction

   // Next digit: load beats en; an illegal load leaves the digit untouched.
   always_comb begin
      digit_d = digit_q;
      carry_d = 1'b0;
      err_d   = 1'b0;
      if (load) begin
         if (load_digit <= MAX_D) begin
            digit_d = load_digit;
         end else begin
            err_d = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            // >= keeps the counter in range even if MAX_DIGIT is odd-sized
            if (digit_q >= MAX_D) begin
               digit_d = 4'd0;
               carry_d = 1'b1;
            end else begin
               digit_d = digit_q + 4'd1;
            end
         end else begin
            if (digit_q == 4'd0) begin
               digit_d = MAX_D;
               carry_d = 1'b1;
            end else begin
               digit_d = digit_q - 4'd1;
            end
         end
      end
      // Encode the next digit so X and digit change on the same edge.
      x_d = gray_enc(digit_d);
   end

`ifdef LAMP_TEST_TIMER_EN
   localparam logic [7:0] LT_LOAD = 8'(LT_CYCLES);

   logic       lt_req_q;
   logic [7:0] lt_cnt_q, lt_cnt_d;

   // Rising edge (re)loads the stretch counter; otherwise count down to 0.
   always_comb begin
      lt_cnt_d = lt_cnt_q;
      if (lamp_test_req && !lt_req_q) begin
         lt_cnt_d = LT_LOAD;
      end else if (lt_cnt_q != 8'd0) begin
         lt_cnt_d = lt_cnt_q - 8'd1;
      end
      // Lamp test is active while the counter that follows this edge is nonzero.
      n_t_d = (lt_cnt_d == 8'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lt_req_q <= 1'b0;
         lt_cnt_q <= 8'd0;
      end else begin
         lt_req_q <= lamp_test_req;
         lt_cnt_q <= lt_cnt_d;
      end
   end
`else
   always_comb begin
      n_t_d = ~lamp_test_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= 4'd0;
         x_q     <= 4'b0000;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
         n_t_q   <= 1'b1;
         n_m_q   <= 1'b1;
      end else begin
         digit_q <= digit_d;
         x_q     <= x_d;
         carry_q <= carry_d;
         err_q   <= err_d;
         n_t_q   <= n_t_d;
         n_m_q   <= ~blank_req;
      end
   end

   assign digit = digit_q;
   assign X     = x_q;
   assign carry = carry_q;
   assign err   = err_q;
   assign n_T   = n_t_q;
   assign n_M   = n_m_q;

endmodule
